// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire reader.
// With DHT_CHECKSUM_EN defined, the checksum helper is also compiled.
package dht11_pkg;

  localparam int FRAME_W    = 40;
  localparam int FRAME_BITS = 40;
  localparam int BIT_CNT_W  = 6;
  localparam int US_CNT_W   = 16;

  localparam int DEF_CLK_FREQ_HZ  = 50_000_000;
  localparam int DEF_START_LOW_US = 18000;
  localparam int DEF_TIMEOUT_US   = 100;
  localparam int DEF_LIMIAR_UM_US = 40;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    INICIO_BAIXO = 4'd1,
    INICIO_SOLTO = 4'd2,
    RESP_BAIXO   = 4'd3,
    RESP_ALTO    = 4'd4,
    BIT_BAIXO    = 4'd5,
    BIT_ALTO     = 4'd6,
    VERIFICA     = 4'd7,
    FIM          = 4'd8,
    ERRO         = 4'd9
  } state_t;

  // States in which a read is in flight and may be aborted by enable=0
  function automatic logic is_busy(input state_t s);
    return (s == INICIO_BAIXO) || (s == INICIO_SOLTO) || (s == RESP_BAIXO) ||
           (s == RESP_ALTO) || (s == BIT_BAIXO) || (s == BIT_ALTO) ||
           (s == VERIFICA);
  endfunction

`ifdef DHT_CHECKSUM_EN
  // Sum of the four data bytes, modulo 256, must match the last byte
  function automatic logic checksum_ok(input logic [FRAME_W-1:0] frame);
    logic [7:0] soma;
    soma = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    return soma == frame[7:0];
  endfunction
`endif

endpackage

// File: rtl/dht11_tick_us.sv
// One-cycle 1 us tick derived from the system clock.
// 'restart' re-phases the prescaler so every FSM state measures time
// from its own entry edge, which keeps the bit threshold exact.
module dht11_tick_us
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int DIV = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == LAST);

  // Prescaler: counts clock cycles modulo DIV, cleared on restart
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (restart || (pcnt == LAST)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/leitor_dht11.sv
// DHT11 reader: issues the host start pulse, follows the sensor response,
// decodes 40 bits by high-time and presents the frame.
// Optional macro DHT_CHECKSUM_EN: reject frames whose checksum is wrong.
module leitor_dht11
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = DEF_CLK_FREQ_HZ,
  parameter int START_LOW_US = DEF_START_LOW_US,
  parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
  parameter int LIMIAR_UM_US = DEF_LIMIAR_UM_US
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  inout  wire                dado,
  output logic [FRAME_W-1:0] saidaDHT,
  output logic               dhtTrabalhando,
  output logic               erroDHT,
  output logic               terminou
);

  localparam logic [US_CNT_W-1:0]  T_START   = US_CNT_W'(START_LOW_US - 1);
  localparam logic [US_CNT_W-1:0]  T_TIMEOUT = US_CNT_W'(TIMEOUT_US - 1);
  localparam logic [US_CNT_W-1:0]  T_LIMIAR  = US_CNT_W'(LIMIAR_UM_US);
  localparam logic [US_CNT_W-1:0]  US_MAX    = '1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(FRAME_BITS - 1);

  state_t state, state_next;

  logic                 sync_1, sync_2, sync_prev;
  logic                 rise, fall;
  logic                 entry;
  logic                 tick;
  logic                 start_done, timed_out;
  logic                 drive_low;
  logic                 chk_ok;
  logic [US_CNT_W-1:0]  us_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [FRAME_W-1:0]   shift;

  assign dado = drive_low ? 1'b0 : 1'bz;

  assign rise       = sync_2 & ~sync_prev;
  assign fall       = ~sync_2 & sync_prev;
  assign entry      = (state_next != state);
  assign start_done = tick && (us_cnt == T_START);
  assign timed_out  = tick && (us_cnt == T_TIMEOUT);

`ifdef DHT_CHECKSUM_EN
  assign chk_ok = checksum_ok(shift);
`else
  assign chk_ok = 1'b1;
`endif

  dht11_tick_us #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(entry),
    .tick   (tick)
  );

  // Two-flop synchronizer plus one history flop for edge detection; the
  // idle bus is pulled high, so everything resets to 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1    <= 1'b1;
      sync_2    <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_1    <= dado;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; waits react to edges so stale levels left over from
  // the host's own start pulse are never mistaken for a sensor response
  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (enable) state_next = INICIO_BAIXO;
      INICIO_BAIXO: if (start_done) state_next = INICIO_SOLTO;
      INICIO_SOLTO: begin
        if (fall) state_next = RESP_BAIXO;
        else if (timed_out) state_next = ERRO;
      end
      RESP_BAIXO: begin
        if (rise) state_next = RESP_ALTO;
        else if (timed_out) state_next = ERRO;
      end
      RESP_ALTO: begin
        if (fall) state_next = BIT_BAIXO;
        else if (timed_out) state_next = ERRO;
      end
      BIT_BAIXO: begin
        if (rise) state_next = BIT_ALTO;
        else if (timed_out) state_next = ERRO;
      end
      BIT_ALTO: begin
        if (fall) state_next = (bit_cnt == LAST_BIT) ? VERIFICA : BIT_BAIXO;
        else if (timed_out) state_next = ERRO;
      end
      VERIFICA:     state_next = chk_ok ? FIM : ERRO;
      FIM, ERRO:    if (!enable) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
    if (!enable && is_busy(state)) begin
      state_next = IDLE;
    end
  end

  // State-decoded outputs; reset forces IDLE, so the bus is released at once
  always_comb begin
    drive_low      = (state == INICIO_BAIXO);
    dhtTrabalhando = is_busy(state);
    terminou       = (state == FIM) || (state == ERRO);
  end

  // Microsecond counter: restarts on every state entry and saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      us_cnt <= '0;
    end else if (entry) begin
      us_cnt <= '0;
    end else if (tick && (us_cnt != US_MAX)) begin
      us_cnt <= us_cnt + 1'b1;
    end
  end

  // Bit shifter; the count reaches only (high time - 1 us) by the time the
  // falling edge is seen, so '>=' here means high time strictly above threshold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if ((state == IDLE) && enable) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if ((state == BIT_ALTO) && fall) begin
      shift   <= {shift[FRAME_W-2:0], (us_cnt >= T_LIMIAR)};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Result registers: updated only when FIM or ERRO is entered, so an
  // aborted read leaves the previous result visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      saidaDHT <= '0;
      erroDHT  <= 1'b0;
    end else if (entry && (state_next == FIM)) begin
      saidaDHT <= shift;
      erroDHT  <= 1'b0;
    end else if (entry && (state_next == ERRO)) begin
      saidaDHT <= '0;
      erroDHT  <= 1'b1;
    end
  end

endmodule

// File: doc/leitor_dht11.md
LEITOR_DHT11 -- requirements
Module: leitor_dht11

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, meaning the system clock frequency used to derive a 1 us tick.
REQ-002 SHALL have parameter START_LOW_US, default 18000, meaning the host start-pulse low time.
REQ-003 SHALL have parameter TIMEOUT_US, default 100, meaning the maximum wait for any single line transition.
REQ-004 SHALL have parameter LIMIAR_UM_US, default 40, meaning the bit high-time threshold: strictly greater decodes as 1.
REQ-005 SHALL have port clk, input, 1 bit: system clock; all logic runs on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: request a read; must stay high until terminou is observed.
REQ-008 SHALL have port dado, inout, 1 bit: DHT11 single-wire bus; block drives 0 or Z only, never 1.
REQ-009 SHALL have port saidaDHT, output, 40 bits: humidity integer, humidity decimal, temperature integer, temperature decimal and checksum, MSB first.
REQ-010 SHALL have port dhtTrabalhando, output, 1 bit: transaction in progress.
REQ-011 SHALL have port erroDHT, output, 1 bit: last transaction failed.
REQ-012 SHALL have port terminou, output, 1 bit: transaction finished; level, held until enable is low.

Function
REQ-013 SHALL synchronize dado through 2 flops before use; all edge decisions use the synchronized value.
REQ-014 SHALL implement the states IDLE, INICIO_BAIXO, INICIO_SOLTO, RESP_BAIXO, RESP_ALTO, BIT_BAIXO, BIT_ALTO, VERIFICA, FIM and ERRO.
REQ-015 IDLE: dado=Z; on enable=1, clear the shift register and go to INICIO_BAIXO on the next cycle.
REQ-016 INICIO_BAIXO: drive dado=0 for START_LOW_US ticks, then go to INICIO_SOLTO.
REQ-017 INICIO_SOLTO: release dado, wait for the line to go low, then go to RESP_BAIXO.
REQ-018 RESP_BAIXO: wait for the line to go high, then go to RESP_ALTO.
REQ-019 RESP_ALTO: wait for the line to go low, then go to BIT_BAIXO.
REQ-020 BIT_BAIXO: on the line going high, reset the us counter and go to BIT_ALTO.
REQ-021 BIT_ALTO: on the line going low, shift in the bit (1 if count > LIMIAR_UM_US, else 0), MSB first.
REQ-022 BIT_ALTO after the 40th bit SHALL go to VERIFICA; otherwise it returns to BIT_BAIXO.
REQ-023 Any wait in REQ-017..REQ-021 SHALL go to ERRO once TIMEOUT_US ticks elapse without the expected level; the us counter resets on every state entry.
REQ-024 VERIFICA: go to FIM, or to ERRO per REQ-036.
REQ-025 FIM: saidaDHT=shift register, terminou=1, erroDHT=0.
REQ-026 ERRO: saidaDHT=0, terminou=1, erroDHT=1.
REQ-027 FIM and ERRO SHALL hold their outputs until enable=0, then go to IDLE; terminou SHALL fall in the same cycle.
REQ-028 enable=0 in any state from INICIO_BAIXO through VERIFICA SHALL abort: release dado, go to IDLE, and leave saidaDHT and erroDHT unchanged.
REQ-029 dhtTrabalhando SHALL be 1 in INICIO_BAIXO through VERIFICA, else 0.
REQ-030 The us counter SHALL saturate and never wrap; it needs at least 15 bits.
REQ-031 saidaDHT SHALL change only on entry to FIM or ERRO.

Reset
REQ-032 reset=1 SHALL force state IDLE, dado=Z, and saidaDHT, dhtTrabalhando, erroDHT and terminou all 0, immediately and asynchronously.
REQ-033 Reset mid-transaction SHALL release the bus within the same cycle.
REQ-034 After reset deassertion, a new read SHALL start only on enable=1 sampled in IDLE.
REQ-035 The tick prescaler and synchronizer SHALL also reset.

Configuration
REQ-036 With DHT_CHECKSUM_EN defined, VERIFICA SHALL require (byte4+byte3+byte2+byte1) mod 256 == byte0, else go to ERRO.
REQ-037 Without DHT_CHECKSUM_EN, VERIFICA SHALL always go to FIM and no adder SHALL be synthesized.

Structure
REQ-038 Package dht11_pkg SHALL hold the state enum, the 40-bit frame width, the bit count of 40 and the default timing constants.
REQ-039 Sub-module dht11_tick_us SHALL generate a one-cycle 1 us tick from CLK_FREQ_HZ, with a 50-cycle period at default.

Verification
REQ-040 Sensor model frame 0x37_00_19_00_50, macro on -> saidaDHT=0x3700190050, terminou=1, erroDHT=0.
REQ-041 Frame 0x37_00_19_00_51: macro on -> erroDHT=1, saidaDHT=0; macro off -> saidaDHT=0x3700190051, erroDHT=0.
REQ-042 No sensor response -> ERRO at 18000+100 us (+/-2 us) after enable, terminou=1, dado=Z.
REQ-043 Bit high times of 27 us and 70 us -> 0 and 1; 41 us -> 1; 40 us -> 0.
REQ-044 reset pulsed during bit 20 -> dado=Z and all outputs 0 immediately; next enable produces a clean, correct frame.
REQ-045 enable dropped in FIM -> terminou=0 next cycle; enable dropped in BIT_BAIXO -> IDLE, dhtTrabalhando=0, no terminou.
